// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target serving a byte-wide register file with an auto-incrementing pointer
// Ports: wb_clk_i/wb_rst_i clock and synchronous reset; scl_i/sda_i asynchronous pad inputs;
//   sda_o/sda_oen_o open-drain SDA (oen=1 pulls low); host_addr_i/host_rdata_o registered host read;
//   wr_stb_o/wr_addr_o/wr_data_o per-byte I2C write events; busy_o high while addressed.
module i2c_target_regfile #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         DEPTH       = 16,
   parameter int         AW          = 4
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_o,
   output logic          sda_oen_o,
   input  logic [AW-1:0] host_addr_i,
   output logic [7:0]    host_rdata_o,
   output logic          wr_stb_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [7:0]    wr_data_o,
   output logic          busy_o
);
   localparam logic [3:0] IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, PTR = 4'd3, PTR_ACK = 4'd4,
                          WR = 4'd5, WR_ACK = 4'd6, RD = 4'd7, RD_ACK = 4'd8, WAIT = 4'd9;
   logic [1:0]    scl_s, sda_s;
   logic          scl_q, sda_q, scl, sda, scl_rise, scl_fall, start, stop;
   logic [3:0]    state;
   logic [2:0]    cnt;
   logic [7:0]    sr, byte_in;
   logic [AW-1:0] ptr;
   logic [7:0]    mem [DEPTH];
   assign scl      = scl_s[1];
   assign sda      = sda_s[1];
   assign scl_rise = scl & ~scl_q;
   assign scl_fall = ~scl & scl_q;
   assign start    = scl & scl_q & sda_q & ~sda;
   assign stop     = scl & scl_q & ~sda_q & sda;
   assign byte_in  = {sr[6:0], sda};
   assign sda_o    = 1'b0;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         scl_s        <= 2'b11;
         sda_s        <= 2'b11;
         scl_q        <= 1'b1;
         sda_q        <= 1'b1;
         state        <= IDLE;
         cnt          <= 3'd0;
         sr           <= 8'h00;
         ptr          <= '0;
         sda_oen_o    <= 1'b0;
         host_rdata_o <= 8'h00;
         wr_stb_o     <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= 8'h00;
         busy_o       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         scl_s        <= {scl_s[0], scl_i};
         sda_s        <= {sda_s[0], sda_i};
         scl_q        <= scl;
         sda_q        <= sda;
         host_rdata_o <= mem[host_addr_i];
         wr_stb_o     <= 1'b0;
         if (start) begin
            state     <= ADDR;
            cnt       <= 3'd0;
            sda_oen_o <= 1'b0;
         end else if (stop) begin
            state     <= IDLE;
            sda_oen_o <= 1'b0;
            busy_o    <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WR: if (scl_rise) begin
                  sr  <= byte_in;
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     if (state == ADDR) begin
                        state  <= byte_in[7:1] == TARGET_ADDR ? ADDR_ACK : WAIT;
                        busy_o <= busy_o | (byte_in[7:1] == TARGET_ADDR);
                     end else if (state == PTR) begin
                        ptr   <= byte_in[AW-1:0];
                        state <= PTR_ACK;
                     end else begin
                        mem[ptr]  <= byte_in;
                        wr_stb_o  <= 1'b1;
                        wr_addr_o <= ptr;
                        wr_data_o <= byte_in;
                        ptr       <= ptr + 1'b1;
                        state     <= WR_ACK;
                     end
                  end
               end
               // first falling edge after the byte starts the ACK, the second ends it;
               // sr[0] still holds the R/W bit of the address byte
               ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
                  if (!sda_oen_o) sda_oen_o <= 1'b1;
                  else if (state == ADDR_ACK && sr[0]) begin
                     sr        <= mem[ptr];
                     sda_oen_o <= ~mem[ptr][7];
                     cnt       <= 3'd0;
                     state     <= RD;
                  end else begin
                     sda_oen_o <= 1'b0;
                     cnt       <= 3'd0;
                     state     <= state == ADDR_ACK ? PTR : WR;
                  end
               end
               // cnt counts bits already driven after the MSB
               RD: if (scl_fall) begin
                  if (cnt == 3'd7) begin
                     sda_oen_o <= 1'b0;
                     ptr       <= ptr + 1'b1;
                     state     <= RD_ACK;
                  end else begin
                     sda_oen_o <= ~sr[3'd6 - cnt];
                     cnt       <= cnt + 3'd1;
                  end
               end
               RD_ACK: if (scl_rise && sda) state <= WAIT;
               else if (scl_fall) begin
                  sr        <= mem[ptr];
                  sda_oen_o <= ~mem[ptr][7];
                  cnt       <= 3'd0;
                  state     <= RD;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bus-level I2C master driving the target against an array model of the register file
module tb_i2c_target_regfile;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1, sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_o, sda_oen_o, wr_stb, busy;
   logic [3:0] host_addr = 4'd0, wr_addr;
   logic [7:0] host_rdata, wr_data;
   int         total = 0, bad = 0;
   logic [7:0] model [16];
   int         ptr_m = 0;
   logic [7:0] wq [$];
   logic [7:0] rbuf [$];
   logic [19:0] stbq [$];
   logic [19:0] exp_stb [$];
   bit         busy_seen = 0, drove = 0;

   always #5 clk = ~clk;
   assign sda_bus = sda_m & ~sda_oen_o;

   i2c_target_regfile dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_o(sda_o), .sda_oen_o(sda_oen_o), .host_addr_i(host_addr), .host_rdata_o(host_rdata),
      .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
   );

   always @(negedge clk) begin
      if (wr_stb) stbq.push_back({wr_addr, wr_data, host_rdata});
      if (busy) busy_seen = 1;
      if (sda_oen_o) drove = 1;
   end

   task wt(input int n);
      repeat (n * 5) @(negedge clk);
   endtask

   task i2c_start;
      sda_m = 1; wt(1); scl_m = 1; wt(1); sda_m = 0; wt(1); scl_m = 0; wt(1);
   endtask

   task i2c_stop;
      sda_m = 0; wt(1); scl_m = 1; wt(1); sda_m = 1; wt(1);
   endtask

   task send_bit(input logic b);
      sda_m = b; wt(1); scl_m = 1; wt(2); scl_m = 0; wt(1);
   endtask

   task recv_bit(output logic b);
      sda_m = 1; wt(1); scl_m = 1; wt(1); b = sda_bus; wt(1); scl_m = 0; wt(1);
   endtask

   task send_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(b);
      ack = !b;
   endtask

   task recv_byte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(!ack);
   endtask

   task host_rd(input logic [3:0] a, output logic [7:0] d);
      host_addr = a;
      @(negedge clk);
      d = host_rdata;
   endtask

   // Address 0x50/W, pointer byte p, then every byte queued in wq; the model follows the same rules.
   task do_write(input logic [7:0] p, input bit stop_end, output int nacks);
      logic ack;
      nacks = 0;
      i2c_start;
      send_byte(8'hA0, ack); nacks += int'(!ack);
      send_byte(p, ack); nacks += int'(!ack);
      ptr_m = int'(p[3:0]);
      foreach (wq[i]) begin
         exp_stb.push_back({4'(ptr_m), wq[i], model[host_addr]});
         model[ptr_m] = wq[i];
         ptr_m = (ptr_m + 1) % 16;
         send_byte(wq[i], ack); nacks += int'(!ack);
      end
      if (stop_end) i2c_stop;
   endtask

   // Address 0x50/R, then n bytes: ACK all but the last, NACK the last. No STOP.
   task do_read(input int n, output int nack);
      logic ack;
      logic [7:0] d;
      i2c_start;
      send_byte(8'hA1, ack);
      nack = int'(!ack);
      rbuf.delete();
      for (int i = 0; i < n; i++) begin
         recv_byte(i < n - 1, d);
         rbuf.push_back(d);
      end
   endtask

   task test_reset;
      logic [7:0] d;
      total++; if (sda_oen_o !== 1'b0) begin bad++; $display("FAIL reset_oen: got %b want 0", sda_oen_o); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (wr_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", wr_stb); end
      total++; if ({wr_addr, wr_data} !== 12'h000) begin bad++; $display("FAIL reset_wr: got %h/%h want 0/00", wr_addr, wr_data); end
      total++; if (host_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", host_rdata); end
      for (int i = 0; i < 4; i++) begin
         host_rd(4'($urandom_range(0, 15)), d);
         total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_reg[%0d]: got %h want 00", host_addr, d); end
      end
   endtask

   task test_write_basic;
      int nacks;
      logic [7:0] d;
      stbq.delete(); exp_stb.delete(); busy_seen = 0;
      host_addr = 4'd4;
      wq = '{8'hA5, 8'h5A};
      do_write(8'h03, 1, nacks);
      wt(1);
      total++; if (nacks !== 0) begin bad++; $display("FAIL wb_acks: got %0d nacks want 0", nacks); end
      total++; if (stbq.size() !== 2) begin bad++; $display("FAIL wb_stb_count: got %0d want 2", stbq.size()); end
      else for (int i = 0; i < 2; i++) begin
         total++; if (stbq[i] !== exp_stb[i]) begin bad++; $display("FAIL wb_stb[%0d]: got %h want %h", i, stbq[i], exp_stb[i]); end
      end
      total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL wb_busy_seen: got %b want 1", busy_seen); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wb_busy_stop: got %b want 0", busy); end
      host_rd(4'd4, d);
      total++; if (d !== 8'h5A) begin bad++; $display("FAIL wb_host4: got %h want 5a", d); end
   endtask

   task test_wrap_read;
      int nacks, nack;
      logic [7:0] d;
      wq = '{8'h11, 8'h22};
      do_write(8'h0F, 0, nacks);
      total++; if (nacks !== 0) begin bad++; $display("FAIL wrap_acks: got %0d nacks want 0", nacks); end
      do_read(2, nack);
      total++; if (nack !== 0) begin bad++; $display("FAIL wrap_rd_ack: got nack want ack"); end
      for (int i = 0; i < 2; i++) begin
         total++; if (rbuf[i] !== model[(ptr_m + i) % 16]) begin bad++; $display("FAIL wrap_rd[%0d]: got %h want %h", i, rbuf[i], model[(ptr_m + i) % 16]); end
      end
      ptr_m = (ptr_m + 2) % 16;
      total++; if (sda_oen_o !== 1'b0) begin bad++; $display("FAIL wrap_release: got oen %b want 0", sda_oen_o); end
      i2c_stop;
      host_rd(4'd15, d);
      total++; if (d !== 8'h11) begin bad++; $display("FAIL wrap_reg15: got %h want 11", d); end
      host_rd(4'd0, d);
      total++; if (d !== 8'h22) begin bad++; $display("FAIL wrap_reg0: got %h want 22", d); end
   endtask

   task test_mismatch(input logic [7:0] abyte);
      logic ack;
      int nacks;
      stbq.delete(); exp_stb.delete(); busy_seen = 0; drove = 0;
      i2c_start;
      send_byte(abyte, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL mm_addr_%h: got ack want nack", abyte); end
      send_byte(8'h77, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL mm_data_%h: got ack want nack", abyte); end
      i2c_stop;
      total++; if (drove !== 1'b0) begin bad++; $display("FAIL mm_drove_%h: got %b want 0", abyte, drove); end
      total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL mm_busy_%h: got %b want 0", abyte, busy_seen); end
      total++; if (stbq.size() !== 0) begin bad++; $display("FAIL mm_stb_%h: got %0d want 0", abyte, stbq.size()); end
      wq = '{8'($urandom)};
      do_write(8'($urandom), 1, nacks);
      total++; if (nacks !== 0) begin bad++; $display("FAIL mm_next: got %0d nacks want 0", nacks); end
      total++; if (stbq.size() !== 1 || stbq[0] !== exp_stb[0]) begin bad++; $display("FAIL mm_next_stb: got %0d entries want %h", stbq.size(), exp_stb[0]); end
   endtask

   task test_preload_read;
      int nacks, nack;
      wq = '{8'hDE, 8'hAD, 8'hBE};
      do_write(8'h00, 1, nacks);
      wq.delete();
      do_write(8'h00, 1, nacks);
      do_read(3, nack);
      i2c_stop;
      total++; if (nack !== 0) begin bad++; $display("FAIL pre_ack: got nack want ack"); end
      total++; if (rbuf[0] !== 8'hDE || rbuf[1] !== 8'hAD || rbuf[2] !== 8'hBE) begin bad++; $display("FAIL pre_data: got %h %h %h want de ad be", rbuf[0], rbuf[1], rbuf[2]); end
      ptr_m = 3;
      do_read(1, nack);
      i2c_stop;
      total++; if (rbuf[0] !== model[3]) begin bad++; $display("FAIL pre_ptr3: got %h want %h", rbuf[0], model[3]); end
      ptr_m = 4;
   endtask

   task test_random;
      int nacks, nack, k;
      logic [7:0] d;
      for (int it = 0; it < 12; it++) begin
         stbq.delete(); exp_stb.delete();
         host_addr = 4'($urandom_range(0, 15));
         wq.delete();
         for (int j = $urandom_range(1, 3); j > 0; j--) wq.push_back(8'($urandom));
         do_write(8'($urandom), 1, nacks);
         total++; if (nacks !== 0) begin bad++; $display("FAIL rnd_wr_ack[%0d]: got %0d nacks want 0", it, nacks); end
         total++; if (stbq.size() !== exp_stb.size()) begin bad++; $display("FAIL rnd_stb_count[%0d]: got %0d want %0d", it, stbq.size(), exp_stb.size()); end
         else foreach (stbq[i]) begin
            total++; if (stbq[i] !== exp_stb[i]) begin bad++; $display("FAIL rnd_stb[%0d.%0d]: got %h want %h", it, i, stbq[i], exp_stb[i]); end
         end
         wq.delete();
         do_write(8'($urandom), 0, nacks);
         k = $urandom_range(1, 4);
         do_read(k, nack);
         i2c_stop;
         total++; if (nack !== 0) begin bad++; $display("FAIL rnd_rd_ack[%0d]: got nack want ack", it); end
         for (int i = 0; i < k; i++) begin
            total++; if (rbuf[i] !== model[(ptr_m + i) % 16]) begin bad++; $display("FAIL rnd_rd[%0d.%0d]: got %h want %h", it, i, rbuf[i], model[(ptr_m + i) % 16]); end
         end
         ptr_m = (ptr_m + k) % 16;
         host_rd(4'($urandom_range(0, 15)), d);
         total++; if (d !== model[host_addr]) begin bad++; $display("FAIL rnd_host[%0d]: got %h want %h", it, d, model[host_addr]); end
      end
   endtask

   task test_reset_midread;
      int nacks;
      logic ack, b;
      logic [7:0] d;
      wq = '{8'h00};
      do_write(8'h07, 1, nacks);
      wq.delete();
      do_write(8'h07, 1, nacks);
      i2c_start;
      send_byte(8'hA1, ack);
      recv_bit(b);
      recv_bit(b);
      total++; if (sda_oen_o !== 1'b1) begin bad++; $display("FAIL rst_driving: got oen %b want 1", sda_oen_o); end
      rst = 1;
      @(negedge clk);
      total++; if (sda_oen_o !== 1'b0) begin bad++; $display("FAIL rst_release: got oen %b want 0", sda_oen_o); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      rst = 0;
      sda_m = 1; scl_m = 1; wt(2);
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      ptr_m = 0;
      stbq.delete(); exp_stb.delete();
      host_rd(4'd3, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_reg3: got %h want 00", d); end
      host_rd(4'd15, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_reg15: got %h want 00", d); end
      wq = '{8'($urandom)};
      do_write(8'($urandom), 1, nacks);
      total++; if (nacks !== 0) begin bad++; $display("FAIL rst_next: got %0d nacks want 0", nacks); end
   endtask

   task test_start_stop;
      int nacks, nack;
      wq = '{8'h3C, 8'h6B};
      do_write(8'h09, 1, nacks);
      wq.delete();
      do_write(8'h0A, 1, nacks);
      drove = 0; busy_seen = 0;
      sda_m = 0; wt(1); sda_m = 1; wt(2);
      total++; if (drove !== 1'b0) begin bad++; $display("FAIL ss_drove: got %b want 0", drove); end
      total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL ss_busy: got %b want 0", busy_seen); end
      do_read(1, nack);
      i2c_stop;
      total++; if (rbuf[0] !== model[ptr_m]) begin bad++; $display("FAIL ss_ptr: got %h want %h", rbuf[0], model[ptr_m]); end
      ptr_m = (ptr_m + 1) % 16;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      repeat (4) @(negedge clk);
      test_reset;
      rst = 0;
      wt(2);
      test_write_basic;
      test_wrap_read;
      test_mismatch(8'hA2);
      test_mismatch(8'h00);
      test_preload_read;
      test_random;
      test_reset_midread;
      test_start_stop;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
